// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter for the SRAM controller word interface with beat-bounded preemption
module sram_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] p0_address,
    input  logic [31:0] p0_wdata,
    input  logic        p0_read,
    input  logic        p0_write,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic [31:0] p1_address,
    input  logic [31:0] p1_wdata,
    input  logic        p1_read,
    input  logic        p1_write,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    output logic [1:0]  grant
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state, nxt;
    logic          last;
    logic [CW-1:0] beat_cnt;
    logic          req0, req1, at_cap, g0, g1;

    assign req0   = p0_read | p0_write;
    assign req1   = p1_read | p1_write;
    assign at_cap = beat_cnt == CW'(MAX_BURST - 1);
    assign g0     = state == GNT0;
    assign g1     = state == GNT1;

    // next owner: round-robin on ties, hand over on release or after the last allowed beat
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = (req0 && (!req1 || last)) ? GNT0 : req1 ? GNT1 : IDLE;
        else if (state == GNT0)
            nxt = !req0 ? (req1 ? GNT1 : IDLE) : (sram_ready && at_cap && req1) ? GNT1 : GNT0;
        else if (state == GNT1)
            nxt = !req1 ? (req0 ? GNT0 : IDLE) : (sram_ready && at_cap && req0) ? GNT0 : GNT1;
    end

    // owner, last-granted port and per-grant beat count; count saturates so a late rival still preempts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                beat_cnt <= '0;
                if (nxt == GNT0) last <= 1'b0;
                if (nxt == GNT1) last <= 1'b1;
            end else if (state != IDLE && sram_ready && !at_cap) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    assign grant        = {g1, g0};
    assign sram_address = g0 ? p0_address : g1 ? p1_address : '0;
    assign sram_wdata   = g0 ? p0_wdata : g1 ? p1_wdata : '0;
    assign sram_write   = g0 ? p0_write : g1 & p1_write;
    assign sram_read    = g0 ? (p0_read & ~p0_write) : g1 & p1_read & ~p1_write;
    assign p0_ready     = g0 & sram_ready;
    assign p1_ready     = g1 & sram_ready;
    assign p0_rdata     = g0 ? sram_rdata : '0;
    assign p1_rdata     = g1 ? sram_rdata : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of grant, forwarding, bursts, preemption and reset
module tb_sram_arbiter;
    logic        clk = 0, rst = 0;
    logic [31:0] p0_address = 0, p0_wdata = 0, p1_address = 0, p1_wdata = 0, sram_rdata = 0;
    logic        p0_read = 0, p0_write = 0, p1_read = 0, p1_write = 0, sram_ready = 0;
    logic [31:0] p0_rdata, p1_rdata, sram_address, sram_wdata;
    logic        p0_ready, p1_ready, sram_read, sram_write;
    logic [1:0]  grant;
    int          n_chk = 0, n_fail = 0;

    sram_arbiter #(.MAX_BURST(2)) dut (
        .clk(clk), .rst(rst),
        .p0_address(p0_address), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_address(p1_address), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_read(sram_read),
        .sram_write(sram_write), .sram_rdata(sram_rdata), .sram_ready(sram_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_sread", sram_read, 0);
        chk("rst_addr", sram_address, 0);
        chk("rst_p0rdy", p0_ready, 0);
        nxt; nxt;
        rst = 0;
        // tie after reset: port 0 first
        p0_write = 1; p0_address = 32'h10; p0_wdata = 32'h11;
        p1_read = 1; p1_address = 32'h20;
        #1 chk("tie_idle", grant, 0);
        nxt; sram_ready = 1;
        #1 chk("tie_g0", grant, 1);
        chk("tie_swr", sram_write, 1);
        chk("tie_srd", sram_read, 0);
        chk("tie_addr", sram_address, 32'h10);
        chk("tie_wd", sram_wdata, 32'h11);
        chk("tie_p0rdy", p0_ready, 1);
        chk("tie_p1rdy", p1_ready, 0);
        nxt; p0_write = 0; sram_ready = 0;
        #1 chk("rel_g", grant, 1);
        chk("rel_swr", sram_write, 0);
        nxt; sram_ready = 1; sram_rdata = 32'h1234;
        #1 chk("tie_g1", grant, 2);
        chk("tie_g1_rd", sram_read, 1);
        chk("tie_g1_addr", sram_address, 32'h20);
        chk("tie_p1rdata", p1_rdata, 32'h1234);
        chk("tie_p0rdata", p0_rdata, 0);
        chk("tie_p1rdy1", p1_ready, 1);
        nxt; p1_read = 0; sram_ready = 0;
        nxt;
        // second tie: last=1 so port 0 again
        p0_read = 1; p0_address = 32'h30; p1_write = 1; p1_address = 32'h50; p1_wdata = 32'h55;
        #1 chk("tie2_idle", grant, 0);
        nxt; sram_ready = 1; sram_rdata = 32'hA5;
        #1 chk("tie2_g0", grant, 1);
        chk("tie2_addr", sram_address, 32'h30);
        chk("tie2_rdata", p0_rdata, 32'hA5);
        nxt; p0_read = 0; sram_ready = 0;
        nxt; sram_ready = 1;
        #1 chk("tie2_g1", grant, 2);
        chk("tie2_swr", sram_write, 1);
        chk("tie2_wd", sram_wdata, 32'h55);
        nxt; p1_write = 0; sram_ready = 0;
        nxt;
        // single port 0 read
        p0_read = 1; p0_address = 32'h40;
        #1 chk("rd_idle", grant, 0);
        nxt;
        #1 chk("rd_g0", grant, 1);
        chk("rd_srd", sram_read, 1);
        chk("rd_addr", sram_address, 32'h40);
        chk("rd_wait", p0_ready, 0);
        nxt; nxt; sram_ready = 1; sram_rdata = 32'hDEADBEEF;
        #1 chk("rd_rdy", p0_ready, 1);
        chk("rd_data", p0_rdata, 32'hDEADBEEF);
        chk("rd_p1rdy", p1_ready, 0);
        nxt; p0_read = 0; sram_ready = 0;
        #1 chk("rd_rel_g", grant, 1);
        chk("rd_rel_srd", sram_read, 0);
        nxt;
        #1 chk("rd_idle2", grant, 0);
        // four-beat burst, no gaps
        p0_write = 1; p0_address = 32'h100; p0_wdata = 1;
        nxt; sram_ready = 1;
        #1 chk("b1_g", grant, 1);
        chk("b1_addr", sram_address, 32'h100);
        chk("b1_rdy", p0_ready, 1);
        nxt; p0_address = 32'h104; p0_wdata = 2;
        #1 chk("b2_g", grant, 1);
        chk("b2_addr", sram_address, 32'h104);
        chk("b2_wr", sram_write, 1);
        chk("b2_rdy", p0_ready, 1);
        nxt; p0_write = 0; p0_read = 1; p0_address = 32'h100; sram_rdata = 1;
        #1 chk("b3_g", grant, 1);
        chk("b3_rd", sram_read, 1);
        chk("b3_data", p0_rdata, 1);
        nxt; p0_address = 32'h104; sram_rdata = 2;
        #1 chk("b4_g", grant, 1);
        chk("b4_addr", sram_address, 32'h104);
        chk("b4_data", p0_rdata, 2);
        nxt; p0_read = 0; sram_ready = 0;
        nxt;
        // preemption with MAX_BURST=2
        p0_read = 1; p0_address = 32'h200;
        nxt; sram_ready = 1; p1_read = 1; p1_address = 32'h300;
        #1 chk("pe1_g", grant, 1);
        chk("pe1_rdy", p0_ready, 1);
        nxt; p0_address = 32'h204;
        #1 chk("pe2_g", grant, 1);
        chk("pe2_rdy", p0_ready, 1);
        nxt; p0_address = 32'h208; sram_ready = 0;
        #1 chk("pe_sw_g", grant, 2);
        chk("pe_sw_addr", sram_address, 32'h300);
        chk("pe_sw_rd", sram_read, 1);
        nxt; sram_ready = 1; sram_rdata = 32'h77;
        #1 chk("pe_p1rdy", p1_ready, 1);
        chk("pe_p1data", p1_rdata, 32'h77);
        chk("pe_p0rdy", p0_ready, 0);
        nxt; p1_read = 0; sram_ready = 0;
        #1 chk("pe_rel_g", grant, 2);
        nxt; sram_ready = 1;
        #1 chk("pe_res_g", grant, 1);
        chk("pe_res_addr", sram_address, 32'h208);
        chk("pe_res_rdy", p0_ready, 1);
        nxt; p0_address = 32'h20C;
        #1 chk("pe4_addr", sram_address, 32'h20C);
        nxt; p0_read = 0; sram_ready = 0;
        nxt;
        // port 1 read and write together: write wins
        p1_read = 1; p1_write = 1; p1_address = 32'h400;
        nxt;
        #1 chk("rw_g", grant, 2);
        chk("rw_swr", sram_write, 1);
        chk("rw_srd", sram_read, 0);
        nxt; p1_read = 0; p1_write = 0;
        nxt;
        // reset mid-beat
        p0_read = 1; p0_address = 32'h500;
        nxt; sram_ready = 1;
        #1 chk("mr_srd", sram_read, 1);
        rst = 1;
        #1 chk("mr_g", grant, 0);
        chk("mr_srd0", sram_read, 0);
        chk("mr_addr", sram_address, 0);
        chk("mr_rdy", p0_ready, 0);
        sram_ready = 0; p1_read = 1; p1_address = 32'h600;
        nxt; rst = 0;
        #1 chk("mr_idle", grant, 0);
        nxt;
        #1 chk("mr_tie", grant, 1);
        chk("mr_tie_addr", sram_address, 32'h500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller word interface between the data cache controller (port 0) and a second requester such as an instruction fetch or DMA unit (port 1). It forwards one port's read/write handshake at a time, and holds the grant across multi-beat transactions such as cache write-back and refill. Round-robin selection applies when both ports request. Beat-bounded preemption prevents either port from starving the other.

## Interface
- MAX_BURST, 4, ready beats a port may complete while the other port waits before the grant is forcibly switched (≥1).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- p0_address / p1_address  in  32  port word address.
- p0_wdata / p1_wdata  in  32  port write data.
- p0_read / p1_read  in  1  port read request (level, held until ready).
- p0_write / p1_write  in  1  port write request (level, held until ready).
- p0_rdata / p1_rdata  out  32  read data, valid when the port's ready is high.
- p0_ready / p1_ready  out  1  one-cycle beat completion for that port.
- sram_address  out  32  to SRAM controller.
- sram_wdata  out  32  to SRAM controller.
- sram_read / sram_write  out  1  to SRAM controller.
- sram_rdata  in  32  from SRAM controller.
- sram_ready  in  1  beat completion from SRAM controller.
- grant  out  2  one-hot current owner, 2'b00 when idle.

## Operation
- reqN = pN_read | pN_write. If both are high on one port, write wins and read is not forwarded.
- States: IDLE, GNT0, GNT1. A registered `last` bit holds the last granted port (reset 1, so port 0 wins the first tie).
- IDLE: nothing is forwarded.
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both → the port ≠ last.
  - None → stay in IDLE.
- GNTx: the sram_* outputs mux port x's address, wdata, read and write combinationally.
  - px_ready = sram_ready and px_rdata = sram_rdata.
  - The other port sees ready=0 and rdata=0.
- beat_cnt counts sram_ready pulses in the current grant. Width is clog2(MAX_BURST+1). It clears on every state change.
- Transitions from GNTx, in priority order:
  - reqx low → GNTy if reqy is high, else IDLE.
  - sram_ready high, beat_cnt == MAX_BURST−1 and reqy high → GNTy (preempt).
  - Otherwise stay in GNTx.
- `last` updates to x on every entry into GNTx.
- A preempted port keeps its request asserted and simply waits; its interrupted sequence resumes when it is re-granted. Preemption only happens after a completed beat, so no SRAM access is ever split.
- In GNTx with reqx low (the cycle after the port's final ready), sram_read and sram_write are 0.

## Timing
- Reset: state IDLE, `last`=1, beat_cnt=0. All outputs are 0: grant, both ports' ready/rdata, and all sram_* outputs. Reset mid-transaction aborts immediately; the SRAM controller shares rst.
- Grant latency: a request rising in IDLE at cycle n is forwarded at cycle n+1.
- Back-to-back beats within a grant add zero cycles. The arbiter is transparent while granted.
- Release latency: one cycle. The cycle after the final ready, req drops, and the next cycle the other port is granted.
- Port switch: sram_read/write are driven by the new owner from the first cycle of GNTy. No cycle mixes the two ports' fields.
- Simultaneous reqx drop and reqy rise in GNTx: go to GNTy. Simultaneous ready and preempt condition with reqx still high: preempt wins.
- MAX_BURST=1 gives strict beat-by-beat alternation under contention.

## Test plan
- Single port 0 read: p0_read=1 with address 0x40, SRAM returns 0xDEADBEEF after 3 cycles. Expect grant=01 one cycle after the request, p0_ready for one cycle with p0_rdata=0xDEADBEEF, p1_ready=0 throughout.
- Tie after reset: p0_write and p1_read asserted in the same cycle. Expect port 0 granted first. Port 1 is granted one cycle after p0 drops its request. Then a second tie grants port 0 again, since last=1.
- Four-beat cache burst (write, write, read, read at 0x100, 0x104, 0x100, 0x104) with port 1 idle. Expect no gap cycles between beats and grant held at 01 throughout.
- Preemption with MAX_BURST=2: port 0 holds a 4-beat burst while port 1 requests from beat 1. Expect a switch to port 1 after p0's second ready. Port 1 completes its beat and drops, then port 0 resumes at its third beat with its address unchanged.
- Both read and write on port 1: expect sram_write=1 and sram_read=0.
- Reset asserted mid-beat while sram_read=1: all outputs go to 0 asynchronously. After release, state is IDLE and the tie goes to port 0.
